// File: rtl/sysbus_pkg.sv
// Shared Sysbus constants, tag layout and arbiter state encoding.
package sysbus_pkg;
  localparam int BEATS = 8;
  localparam int TAGW  = 13;

  localparam logic       READ   = 1'b0;
  localparam logic       WRITE  = 1'b1;
  localparam logic [3:0] MEMORY = 4'h8;

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RWAIT} arb_state_t;

  typedef struct packed {
    logic       rw;
    logic [3:0] typ;
    logic [7:0] id;
  } bus_tag_t;
endpackage

// File: rtl/sysbus_arbiter_rr.sv
// Two-input round-robin grant: under contention the port that did not win last time wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_id,
  output logic       grant_vld
);
  always_comb begin
    grant_vld = |req;
    grant_id  = req[1];
    if (&req) grant_id = ~last_grant;
  end
endmodule

// File: rtl/sysbus_arbiter.sv
// Sysbus master-port arbiter: fetch (port 0) and data (port 1) share the bus one
// whole 8-beat transaction at a time, round-robin under contention.
module sysbus_arbiter
  import sysbus_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            rq_cyc,
  input  logic [1:0][63:0]      rq_addr,
  input  logic [1:0][TAGW-1:0]  rq_tag,
  input  logic [1:0][63:0]      rq_wdata,
  output logic [1:0]            rq_ack,
  output logic [1:0]            rq_wready,
  output logic [1:0]            rq_respcyc,
  output logic [63:0]           rq_resp,
  output logic [1:0]            rq_done,
  output logic                  bus_reqcyc,
  output logic [63:0]           bus_req,
  output logic [TAGW-1:0]       bus_reqtag,
  input  logic                  bus_reqack,
  input  logic                  bus_respcyc,
  input  logic [63:0]           bus_resp,
  input  logic [TAGW-1:0]       bus_resptag,
  output logic                  bus_respack,
  output logic                  stray_resp
);
  arb_state_t state, state_n;
  logic       owner, last_grant;
  logic [2:0] count;
  bus_tag_t   req_tag_q, gnt_tag;
  logic       gnt_id, gnt_vld;
  logic       is_wr, last_beat, beat_ok;

  rr_arbiter2 u_rr (
    .req        (rq_cyc),
    .last_grant (last_grant),
    .grant_id   (gnt_id),
    .grant_vld  (gnt_vld)
  );

  assign gnt_tag     = rq_tag[gnt_id];
  assign is_wr       = (req_tag_q.rw == WRITE);
  assign last_beat   = (count == 3'(BEATS - 1));
  assign beat_ok     = bus_respcyc && (state == RWAIT) && (bus_resptag[0] == owner);
  assign bus_reqtag  = req_tag_q;
  assign rq_resp     = bus_resp;
  // Responses are always drained; anything not owned by the live read is flagged.
  assign bus_respack = bus_respcyc;
  assign stray_resp  = bus_respcyc && !beat_ok;

  logic unused_bits;
  assign unused_bits = ^{rq_addr[0][5:0], rq_addr[1][5:0], rq_tag[0][7:0],
                         rq_tag[1][7:0], bus_resptag[TAGW-1:1], gnt_tag.id};

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    rq_ack     = '0;
    rq_wready  = '0;
    rq_respcyc = '0;
    rq_done    = '0;
    case (state)
      IDLE:  if (gnt_vld) state_n = REQ;
      REQ:   if (bus_reqack) begin
        rq_ack[owner] = 1'b1;
        state_n       = is_wr ? WDATA : RWAIT;
      end
      WDATA: if (bus_reqack) begin
        rq_wready[owner] = 1'b1;
        if (last_beat) begin
          rq_done[owner] = 1'b1;
          state_n        = IDLE;
        end
      end
      RWAIT: if (beat_ok) begin
        rq_respcyc[owner] = 1'b1;
        if (last_beat) begin
          rq_done[owner] = 1'b1;
          state_n        = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      count      <= '0;
      bus_reqcyc <= 1'b0;
      bus_req    <= '0;
      req_tag_q  <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          owner      <= gnt_id;
          last_grant <= gnt_id;
          count      <= '0;
          bus_reqcyc <= 1'b1;
          bus_req    <= {rq_addr[gnt_id][63:6], 6'b0};
          req_tag_q  <= '{rw: gnt_tag.rw, typ: gnt_tag.typ, id: {7'b0, gnt_id}};
        end
        REQ: if (bus_reqack) begin
          if (is_wr) begin
            bus_req <= rq_wdata[owner];
            count   <= '0;
          end else begin
            bus_reqcyc <= 1'b0;
          end
        end
        // The beat loaded here is the one the requester presents after wready.
        WDATA: if (bus_reqack) begin
          count <= count + 3'd1;
          if (last_beat) bus_reqcyc <= 1'b0;
          else           bus_req    <= rq_wdata[owner];
        end
        RWAIT: if (beat_ok) count <= count + 3'd1;
        default: ;
      endcase
    end
  end

  a_hold_cyc: assert property (@(posedge clk) disable iff (!reset)
    (state == REQ) |-> rq_cyc[owner]);
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Scoreboard bench for sysbus_arbiter: expected bus handshakes, grants and
// response beats are queued as stimulus is driven and checked as they appear.
module tb_sysbus_arbiter;
  import sysbus_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       rq_cyc;
  logic [1:0][63:0] rq_addr;
  logic [1:0][12:0] rq_tag;
  logic [1:0][63:0] rq_wdata;
  logic [1:0]       rq_ack, rq_wready, rq_respcyc, rq_done;
  logic [63:0]      rq_resp;
  logic             bus_reqcyc;
  logic [63:0]      bus_req;
  logic [12:0]      bus_reqtag;
  logic             bus_reqack, bus_respcyc;
  logic [63:0]      bus_resp;
  logic [12:0]      bus_resptag;
  logic             bus_respack, stray_resp;

  sysbus_arbiter dut (
    .clk(clk), .reset(reset), .rq_cyc(rq_cyc), .rq_addr(rq_addr), .rq_tag(rq_tag),
    .rq_wdata(rq_wdata), .rq_ack(rq_ack), .rq_wready(rq_wready), .rq_respcyc(rq_respcyc),
    .rq_resp(rq_resp), .rq_done(rq_done), .bus_reqcyc(bus_reqcyc), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .stray_resp(stray_resp)
  );

  always #5 clk = ~clk;

  // Port 1 write-data source: advances after each beat the arbiter has registered.
  int widx = 0;
  always @(posedge clk)
    if (rq_wready[1] || (rq_ack[1] && rq_tag[1][12])) widx <= widx + 1;
  assign rq_wdata = {64'hD0 + 64'(widx), 64'h0};

  typedef struct packed { logic [63:0] data; logic [12:0] tag; } bexp_t;
  bexp_t       exp_bus[$];
  int          exp_grant[$];
  logic [63:0] exp_resp0[$], exp_resp1[$];
  int n_checks = 0, n_fail = 0;
  int ack_cnt[2], wr_cnt[2], resp_cnt[2], done_cnt[2];

  task automatic mon();
    bexp_t e; int g; logic [63:0] r;
    if (reset) begin
      if (bus_reqcyc && bus_reqack) begin
        n_checks++;
        if (exp_bus.size() == 0) begin
          n_fail++; $display("FAIL bus_handshake: unexpected req=%h tag=%h", bus_req, bus_reqtag);
        end else begin
          e = exp_bus.pop_front();
          if (bus_req !== e.data || bus_reqtag !== e.tag) begin
            n_fail++; $display("FAIL bus_handshake: got req=%h tag=%h want req=%h tag=%h",
                               bus_req, bus_reqtag, e.data, e.tag);
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (rq_ack[p]) begin
          n_checks++;
          g = (exp_grant.size() == 0) ? -1 : exp_grant.pop_front();
          if (g != p) begin n_fail++; $display("FAIL grant_order: got port %0d want %0d", p, g); end
        end
        if (rq_respcyc[p]) begin
          n_checks++;
          if ((p == 0 ? exp_resp0.size() : exp_resp1.size()) == 0) begin
            n_fail++; $display("FAIL resp_beat%0d: unexpected data %h", p, rq_resp);
          end else begin
            r = (p == 0) ? exp_resp0.pop_front() : exp_resp1.pop_front();
            if (rq_resp !== r) begin
              n_fail++; $display("FAIL resp_beat%0d: got %h want %h", p, rq_resp, r);
            end
          end
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      ack_cnt[p]  += int'(rq_ack[p]);
      wr_cnt[p]   += int'(rq_wready[p]);
      resp_cnt[p] += int'(rq_respcyc[p]);
      done_cnt[p] += int'(rq_done[p]);
    end
  endtask

  task automatic half(); @(negedge clk); mon(); endtask
  task automatic rise(); @(posedge clk); #1; endtask
  task automatic tick(); half(); rise(); endtask

  task automatic run_read(input int p, input logic [63:0] addr, input logic [63:0] base,
                          input int delay, input int bad_at, input int nbeats, output int lat);
    rq_addr[p] = addr; rq_tag[p] = 13'h0800; rq_cyc[p] = 1'b1;
    exp_bus.push_back({{addr[63:6], 6'b0}, 13'h0800 | 13'(p)});
    exp_grant.push_back(p);
    for (int i = 0; i < nbeats; i++)
      if (p == 0) exp_resp0.push_back(base + 64'(i)); else exp_resp1.push_back(base + 64'(i));
    lat = 0;
    while (bus_reqcyc !== 1'b1 && lat < 16) begin tick(); lat++; end
    if (lat >= 16) begin
      n_checks++; n_fail++; $display("FAIL req_timeout: port %0d bus_reqcyc never rose", p);
    end
    repeat (delay) tick();
    bus_reqack = 1'b1; tick(); bus_reqack = 1'b0; rq_cyc[p] = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (i == bad_at) begin
        bus_respcyc = 1'b1; bus_resp = 64'hBAD; bus_resptag = (p == 0) ? 13'h1 : 13'h0;
        half(); n_checks++;
        if (stray_resp !== 1'b1 || rq_respcyc !== 2'b00) begin
          n_fail++; $display("FAIL mismatched_tag: stray=%b respcyc=%b want 1/00", stray_resp, rq_respcyc);
        end
        rise();
      end
      bus_respcyc = 1'b1; bus_resp = base + 64'(i); bus_resptag = 13'(p);
      half(); n_checks++;
      if (rq_done[p] !== (i == BEATS - 1) || stray_resp !== 1'b0) begin
        n_fail++; $display("FAIL read_beat%0d: done=%b stray=%b want done=%b stray=0",
                           i, rq_done[p], stray_resp, i == BEATS - 1);
      end
      rise();
    end
    bus_respcyc = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; tick(); tick();
    n_checks++;
    if ({bus_reqcyc, bus_req, bus_reqtag} !== '0 ||
        {rq_ack, rq_wready, rq_respcyc, rq_done, stray_resp, bus_respack} !== '0) begin
      n_fail++; $display("FAIL reset_state: reqcyc=%b req=%h tag=%h pulses=%b", bus_reqcyc, bus_req,
                         bus_reqtag, {rq_ack, rq_wready, rq_respcyc, rq_done, stray_resp});
    end
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    int a1, r1, d1, w1, lat;
    a1 = ack_cnt[1]; r1 = resp_cnt[1]; d1 = done_cnt[1]; w1 = wr_cnt[1];
    run_read(0, 64'h1234_5678, 64'hA0, 3, -1, BEATS, lat);
    n_checks++;
    if (lat != 1) begin n_fail++; $display("FAIL req_latency: got %0d cycles want 1", lat); end
    n_checks++;
    if (ack_cnt[0] != 1 || resp_cnt[0] != 8 || done_cnt[0] != 1) begin
      n_fail++; $display("FAIL read0_counts: ack=%0d resp=%0d done=%0d want 1/8/1",
                         ack_cnt[0], resp_cnt[0], done_cnt[0]);
    end
    n_checks++;
    if (ack_cnt[1] != a1 || resp_cnt[1] != r1 || done_cnt[1] != d1 || wr_cnt[1] != w1) begin
      n_fail++; $display("FAIL port1_quiet: port 1 pulsed during port 0 read");
    end
  endtask

  task automatic test_write();
    int w0, d0, lat;
    w0 = wr_cnt[1]; d0 = done_cnt[1];
    rq_addr[1] = 64'h8000_00C0; rq_tag[1] = 13'h1800; rq_cyc[1] = 1'b1;
    exp_bus.push_back({64'h8000_00C0, 13'h1801});
    for (int i = 0; i < BEATS; i++) exp_bus.push_back({64'hD0 + 64'(i), 13'h1801});
    exp_grant.push_back(1);
    lat = 0;
    while (bus_reqcyc !== 1'b1 && lat < 16) begin tick(); lat++; end
    tick();
    bus_reqack = 1'b1; tick(); bus_reqack = 1'b0; rq_cyc[1] = 1'b0;
    for (int i = 0; i < BEATS; i++) begin
      tick();
      bus_reqack = 1'b1; half(); n_checks++;
      if (rq_wready[1] !== 1'b1 || rq_done[1] !== (i == BEATS - 1)) begin
        n_fail++; $display("FAIL write_beat%0d: wready=%b done=%b", i, rq_wready[1], rq_done[1]);
      end
      rise(); bus_reqack = 1'b0;
    end
    n_checks++;
    if (bus_reqcyc !== 1'b0) begin n_fail++; $display("FAIL write_end: bus_reqcyc=%b want 0", bus_reqcyc); end
    n_checks++;
    if (wr_cnt[1] - w0 != 8 || done_cnt[1] - d0 != 1) begin
      n_fail++; $display("FAIL write_counts: wready=%0d done=%0d want 8/1", wr_cnt[1] - w0, done_cnt[1] - d0);
    end
  endtask

  task automatic test_contention();
    int lat, o, d;
    reset = 1'b0;
    rq_addr[0] = 64'h1000; rq_addr[1] = 64'h2000;
    rq_tag[0] = 13'h0800; rq_tag[1] = 13'h0800; rq_cyc = 2'b11;
    tick(); tick(); reset = 1'b1;
    d = done_cnt[0] + done_cnt[1];
    for (int t = 0; t < 4; t++) begin
      o = t % 2;
      exp_bus.push_back({(o == 0) ? 64'h1000 : 64'h2000, 13'h0800 | 13'(o)});
      exp_grant.push_back(o);
      for (int i = 0; i < BEATS; i++)
        if (o == 0) exp_resp0.push_back(64'h100 * (t + 1) + 64'(i));
        else        exp_resp1.push_back(64'h100 * (t + 1) + 64'(i));
      lat = 0;
      while (bus_reqcyc !== 1'b1 && lat < 16) begin tick(); lat++; end
      if (lat >= 16) begin n_checks++; n_fail++; $display("FAIL contention_timeout: txn %0d", t); end
      tick();
      bus_reqack = 1'b1; tick(); bus_reqack = 1'b0; rq_cyc[o] = 1'b0;
      for (int i = 0; i < BEATS; i++) begin
        bus_respcyc = 1'b1; bus_resp = 64'h100 * (t + 1) + 64'(i); bus_resptag = 13'(o);
        tick();
      end
      bus_respcyc = 1'b0;
      n_checks++;
      if (bus_reqcyc !== 1'b0) begin n_fail++; $display("FAIL no_overlap: txn %0d reqcyc=%b want 0", t, bus_reqcyc); end
      if (t < 2) rq_cyc[o] = 1'b1;
    end
    n_checks++;
    if (done_cnt[0] + done_cnt[1] - d != 4) begin
      n_fail++; $display("FAIL contention_done: got %0d want 4", done_cnt[0] + done_cnt[1] - d);
    end
  endtask

  task automatic test_stray();
    int lat, d0;
    bus_respcyc = 1'b1; bus_resp = 64'h55; bus_resptag = 13'h0;
    half(); n_checks++;
    if (stray_resp !== 1'b1 || bus_respack !== 1'b1 || rq_respcyc !== 2'b00) begin
      n_fail++; $display("FAIL idle_stray: stray=%b respack=%b respcyc=%b want 1/1/00",
                         stray_resp, bus_respack, rq_respcyc);
    end
    rise(); bus_respcyc = 1'b0;
    d0 = done_cnt[0];
    run_read(0, 64'h3000, 64'hB0, 1, 3, BEATS, lat);
    n_checks++;
    if (done_cnt[0] - d0 != 1) begin n_fail++; $display("FAIL stray_read_done: got %0d want 1", done_cnt[0] - d0); end
  endtask

  task automatic test_reset_mid_read();
    int lat, d0;
    run_read(0, 64'h4000, 64'hC0, 1, -1, 3, lat);
    reset = 1'b0; tick(); tick();
    n_checks++;
    if ({bus_reqcyc, bus_req, bus_reqtag} !== '0 ||
        {rq_ack, rq_wready, rq_respcyc, rq_done, stray_resp} !== '0) begin
      n_fail++; $display("FAIL midreset_state: reqcyc=%b req=%h tag=%h", bus_reqcyc, bus_req, bus_reqtag);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_respcyc = 1'b1; bus_resp = 64'hC3 + 64'(i); bus_resptag = 13'h0;
      half(); n_checks++;
      if (stray_resp !== 1'b1 || bus_respack !== 1'b1 || rq_respcyc !== 2'b00) begin
        n_fail++; $display("FAIL orphan_beat%0d: stray=%b respack=%b respcyc=%b", i, stray_resp,
                           bus_respack, rq_respcyc);
      end
      rise();
    end
    bus_respcyc = 1'b0;
    d0 = done_cnt[0];
    run_read(0, 64'h5000, 64'hE0, 0, -1, BEATS, lat);
    n_checks++;
    if (done_cnt[0] - d0 != 1) begin n_fail++; $display("FAIL post_reset_read: done=%0d want 1", done_cnt[0] - d0); end
  endtask

  initial begin
    reset = 1'b0; rq_cyc = '0; rq_addr = '0; rq_tag = '0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    for (int p = 0; p < 2; p++) begin ack_cnt[p] = 0; wr_cnt[p] = 0; resp_cnt[p] = 0; done_cnt[p] = 0; end
    rise();
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_stray();
    test_reset_mid_read();
    tick();
    n_checks++;
    if (exp_bus.size() != 0 || exp_grant.size() != 0 || exp_resp0.size() != 0 || exp_resp1.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: left bus=%0d grant=%0d resp0=%0d resp1=%0d",
                         exp_bus.size(), exp_grant.size(), exp_resp0.size(), exp_resp1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
